// File: rtl/signal_phase_controller.sv
// signal_phase_controller: green/yellow/all-red sequencer with green length sized from the served approach's average.
// Optional EMERGENCY_PREEMPT_EN adds emerg_req/emerg_road preemption.
module signal_phase_controller #(
  parameter int MIN_GREEN   = 8,
  parameter int MAX_GREEN   = 60,
  parameter int GREEN_SHIFT = 2,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 1,
  parameter int SKIP_THRESH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] avg_n,
  input  logic [7:0] avg_e,
  input  logic [7:0] avg_s,
  input  logic [7:0] avg_w,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic [1:0] emerg_road,
`endif
  output logic [1:0] next_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [1:0] phase,
  output logic       road_change
);
  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_ALLRED = 2'd2;
  localparam logic [7:0] SKIP      = 8'(SKIP_THRESH);
  logic [7:0] avg [4];
  logic [7:0] timer, g_len;
  logic [9:0] g_raw;
  logic [1:0] r1, r2, r3, sel, road_new;
  logic [3:0] hot;
  logic       preempt, hold;
  always_comb begin
    avg[0] = avg_n;
    avg[1] = avg_e;
    avg[2] = avg_s;
    avg[3] = avg_w;
    r1 = next_road + 2'd1;
    r2 = next_road + 2'd2;
    r3 = next_road + 2'd3;
    sel = avg[r1] >= SKIP ? r1 : avg[r2] >= SKIP ? r2 : avg[r3] >= SKIP ? r3 : r1;
    g_raw = 10'(MIN_GREEN) + 10'(avg[next_road] >> GREEN_SHIFT);
    g_len = g_raw > 10'(MAX_GREEN) ? 8'(MAX_GREEN) : g_raw[7:0];
    hot = 4'b0001 << next_road;
  end
`ifdef EMERGENCY_PREEMPT_EN
  logic       pend;
  logic [1:0] pend_road;
  assign preempt  = emerg_req && phase == PH_GREEN && next_road != emerg_road;
  assign hold     = emerg_req && phase == PH_GREEN && next_road == emerg_road;
  assign road_new = emerg_req ? emerg_road : pend ? pend_road : sel;
  // a request seen outside the served road's green is remembered until the next selection consumes it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend      <= 1'b0;
      pend_road <= 2'd0;
    end else if (phase == PH_YELLOW && tick && timer == 8'd0) begin
      pend <= 1'b0;
    end else if (emerg_req && !hold) begin
      pend      <= 1'b1;
      pend_road <= emerg_road;
    end
`else
  assign preempt  = 1'b0;
  assign hold     = 1'b0;
  assign road_new = sel;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      next_road   <= 2'd0;
      phase       <= PH_ALLRED;
      timer       <= 8'(ALLRED_T - 1);
      green       <= 4'd0;
      yellow      <= 4'd0;
      road_change <= 1'b0;
    end else begin
      road_change <= 1'b0;
      if (preempt) begin
        phase  <= PH_YELLOW;
        timer  <= 8'(YELLOW_T - 1);
        green  <= 4'd0;
        yellow <= hot;
      end else if (tick && !hold) begin
        if (timer != 8'd0) begin
          timer <= timer - 8'd1;
        end else if (phase == PH_GREEN) begin
          phase  <= PH_YELLOW;
          timer  <= 8'(YELLOW_T - 1);
          green  <= 4'd0;
          yellow <= hot;
        end else if (phase == PH_YELLOW) begin
          phase       <= PH_ALLRED;
          timer       <= 8'(ALLRED_T - 1);
          yellow      <= 4'd0;
          next_road   <= road_new;
          road_change <= 1'b1;
        end else begin
          phase <= PH_GREEN;
          timer <= g_len - 8'd1;
          green <= hot;
        end
      end
    end
endmodule
